// File: rtl/stepper_cmd_if.sv
// Byte-stream and command-bus bundle for the stepper command parser.
// The master modport is the parser; the slave modport is the rx source plus the motor-stage consumer.
interface stepper_cmd_if #(
    parameter int ERR_W = 8
);
    logic [7:0]       rx_byte;
    logic             rbyte_ready;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_motor;
    logic             cmd_dir;
    logic             cmd_half;
    logic [15:0]      cmd_steps;
    logic             pkt_err;
    logic [ERR_W-1:0] err_cnt;

    // Handshake: a command transfers on any rising clk edge where cmd_valid & cmd_ready are both 1.
    // cmd_* stay stable while cmd_valid=1. rbyte_ready is a 1-cycle strobe that is never back-pressured.
    modport master (
        input  rx_byte, rbyte_ready, cmd_ready,
        output cmd_valid, cmd_motor, cmd_dir, cmd_half, cmd_steps, pkt_err, err_cnt
    );

    modport slave (
        output rx_byte, rbyte_ready, cmd_ready,
        input  cmd_valid, cmd_motor, cmd_dir, cmd_half, cmd_steps, pkt_err, err_cnt
    );
endinterface

// File: rtl/stepper_cmd_parser.sv
// Framed command parser: SYNC, ctrl, steps_hi, steps_lo [, checksum] -> one held command on a valid/ready bus.
// Optional feature macro: CMD_CHECKSUM_EN (adds the trailing XOR checksum byte and the CSUM state).
module stepper_cmd_parser #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter int         ERR_W          = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    stepper_cmd_if.master        bus,
    output logic [2:0]           state_o
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CTRL  = 3'd1,
        S_STEPH = 3'd2,
`ifdef CMD_CHECKSUM_EN
        S_STEPL = 3'd3,
        S_CSUM  = 3'd4
`else
        S_STEPL = 3'd3
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [3:0]         ctrl_q, ctrl_d;        // {dir, half, motor[1:0]}
    logic [7:0]         steps_h_q, steps_h_d;
`ifdef CMD_CHECKSUM_EN
    logic [7:0]         steps_l_q, steps_l_d;
    logic [7:0]         xor_q, xor_d;
`endif
    logic               valid_q, valid_d;
    logic [3:0]         cmd_ctrl_q, cmd_ctrl_d;
    logic [15:0]        cmd_steps_q, cmd_steps_d;
    logic               pkt_err_q, pkt_err_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
    logic               commit;
    logic               err;
    logic [15:0]        new_steps;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            ctrl_q      <= '0;
            steps_h_q   <= '0;
`ifdef CMD_CHECKSUM_EN
            steps_l_q   <= '0;
            xor_q       <= '0;
`endif
            valid_q     <= 1'b0;
            cmd_ctrl_q  <= '0;
            cmd_steps_q <= '0;
            pkt_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            ctrl_q      <= ctrl_d;
            steps_h_q   <= steps_h_d;
`ifdef CMD_CHECKSUM_EN
            steps_l_q   <= steps_l_d;
            xor_q       <= xor_d;
`endif
            valid_q     <= valid_d;
            cmd_ctrl_q  <= cmd_ctrl_d;
            cmd_steps_q <= cmd_steps_d;
            pkt_err_q   <= pkt_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        ctrl_d      = ctrl_q;
        steps_h_d   = steps_h_q;
`ifdef CMD_CHECKSUM_EN
        steps_l_d   = steps_l_q;
        xor_d       = xor_q;
`endif
        valid_d     = valid_q;
        cmd_ctrl_d  = cmd_ctrl_q;
        cmd_steps_d = cmd_steps_q;
        commit      = 1'b0;
        err         = 1'b0;
        new_steps   = {steps_h_q, bus.rx_byte};

        if (bus.rbyte_ready || state_q == S_IDLE) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + 1'b1;
        end

        // A strobe always wins over a timeout landing in the same cycle.
        if (bus.rbyte_ready) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.rx_byte == SYNC_BYTE) state_d = S_CTRL;
                end
                S_CTRL: begin
                    if (bus.rx_byte[5:2] != 4'd0) begin
                        err     = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ctrl_d  = {bus.rx_byte[7], bus.rx_byte[6], bus.rx_byte[1:0]};
                        state_d = S_STEPH;
`ifdef CMD_CHECKSUM_EN
                        xor_d   = bus.rx_byte;
`endif
                    end
                end
                S_STEPH: begin
                    steps_h_d = bus.rx_byte;
                    state_d   = S_STEPL;
`ifdef CMD_CHECKSUM_EN
                    xor_d     = xor_q ^ bus.rx_byte;
`endif
                end
`ifdef CMD_CHECKSUM_EN
                S_STEPL: begin
                    steps_l_d = bus.rx_byte;
                    xor_d     = xor_q ^ bus.rx_byte;
                    state_d   = S_CSUM;
                end
                S_CSUM: begin
                    state_d   = S_IDLE;
                    new_steps = {steps_h_q, steps_l_q};
                    if (bus.rx_byte == xor_q) commit = 1'b1;
                    else                      err    = 1'b1;
                end
`else
                S_STEPL: begin
                    commit  = 1'b1;
                    state_d = S_IDLE;
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE && timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
            err     = 1'b1;
            state_d = S_IDLE;
            timer_d = '0;
        end

        // A commit can reuse the slot being handed off this very edge; otherwise it is an overrun.
        if (commit) begin
            if (!valid_q || bus.cmd_ready) begin
                valid_d     = 1'b1;
                cmd_ctrl_d  = ctrl_q;
                cmd_steps_d = new_steps;
            end else begin
                err = 1'b1;
            end
        end else if (valid_q && bus.cmd_ready) begin
            valid_d = 1'b0;
        end

        pkt_err_d = err;
        err_cnt_d = (err && err_cnt_q != '1) ? err_cnt_q + 1'b1 : err_cnt_q;
    end

    assign bus.cmd_valid = valid_q;
    assign bus.cmd_dir   = cmd_ctrl_q[3];
    assign bus.cmd_half  = cmd_ctrl_q[2];
    assign bus.cmd_motor = cmd_ctrl_q[1:0];
    assign bus.cmd_steps = cmd_steps_q;
    assign bus.pkt_err   = pkt_err_q;
    assign bus.err_cnt   = err_cnt_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_stepper_cmd_parser.sv
// Directed bench for stepper_cmd_parser; follows CMD_CHECKSUM_EN to choose 5- or 4-byte packets.
module tb_stepper_cmd_parser;
    localparam int TO = 12;
    localparam int EW = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] state_dbg;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         exp_err = 0;

    stepper_cmd_if #(.ERR_W(EW)) bus ();

    stepper_cmd_parser #(
        .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TO), .ERR_W(EW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .state_o(state_dbg)
    );

    always #5 clk = ~clk;

    // Drivers: each call starts just after a rising edge and returns just after the next one.
    task automatic send_byte(input logic [7:0] b);
        bus.rx_byte     = b;
        bus.rbyte_ready = 1'b1;
        @(posedge clk); #1;
        bus.rbyte_ready = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] c, input logic [7:0] sh, input logic [7:0] sl);
        send_byte(8'hA5);
        send_byte(c);
        send_byte(sh);
        send_byte(sl);
`ifdef CMD_CHECKSUM_EN
        send_byte(c ^ sh ^ sl);
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.rx_byte = 8'h00;
        bus.rbyte_ready = 1'b0;
        bus.cmd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.cmd_valid, bus.cmd_dir, bus.cmd_half, bus.cmd_motor, bus.cmd_steps, bus.pkt_err} !== 22'd0
            || bus.err_cnt !== 8'd0 || state_dbg !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_state: got v=%0b m=%0d s=%0d e=%0b cnt=%0d st=%0d, want all 0",
                     bus.cmd_valid, bus.cmd_motor, bus.cmd_steps, bus.pkt_err, bus.err_cnt, state_dbg);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        bus.cmd_ready = 1'b1;
        send_pkt(8'h81, 8'h01, 8'hF4);
        n_cmp++;
        if ({bus.cmd_valid, bus.cmd_dir, bus.cmd_half, bus.cmd_motor, bus.cmd_steps} !== {1'b1, 1'b1, 1'b0, 2'd1, 16'd500}) begin
            n_bad++;
            $display("FAIL basic_cmd: got v=%0b d=%0b h=%0b m=%0d s=%0d, want v=1 d=1 h=0 m=1 s=500",
                     bus.cmd_valid, bus.cmd_dir, bus.cmd_half, bus.cmd_motor, bus.cmd_steps);
        end
        n_cmp++;
        if (bus.err_cnt !== 8'd0 || bus.pkt_err !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_noerr: got cnt=%0d e=%0b, want 0 0", bus.err_cnt, bus.pkt_err);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (bus.cmd_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_drop_valid: got %0b want 0", bus.cmd_valid);
        end
    endtask

`ifdef CMD_CHECKSUM_EN
    task automatic test_checksum();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00); send_byte(8'h10); send_byte(8'h13);
        exp_err++;
        n_cmp++;
        if (bus.pkt_err !== 1'b1 || bus.cmd_valid !== 1'b0 || bus.err_cnt !== 8'(exp_err)) begin
            n_bad++;
            $display("FAIL cksum_bad: got e=%0b v=%0b cnt=%0d, want e=1 v=0 cnt=%0d",
                     bus.pkt_err, bus.cmd_valid, bus.err_cnt, exp_err);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (bus.pkt_err !== 1'b0) begin
            n_bad++;
            $display("FAIL cksum_pulse_width: got %0b want 0", bus.pkt_err);
        end
        send_pkt(8'h02, 8'h00, 8'h10);
        n_cmp++;
        if ({bus.cmd_valid, bus.cmd_dir, bus.cmd_half, bus.cmd_motor, bus.cmd_steps} !== {1'b1, 1'b0, 1'b0, 2'd2, 16'h0010}) begin
            n_bad++;
            $display("FAIL cksum_good: got v=%0b m=%0d s=%0h, want v=1 m=2 s=10",
                     bus.cmd_valid, bus.cmd_motor, bus.cmd_steps);
        end
        @(posedge clk); #1;
    endtask
`endif

    task automatic test_timeout();
        int waited;
        waited = 0;
        send_byte(8'hA5);
        send_byte(8'h81);
        for (int i = 1; i <= TO + 4; i++) begin
            @(posedge clk); #1;
            if (bus.pkt_err === 1'b1) begin
                waited = i;
                break;
            end
        end
        exp_err++;
        n_cmp++;
        if (waited !== TO) begin
            n_bad++;
            $display("FAIL timeout_cycles: got %0d (0 = never) want %0d", waited, TO);
        end
        n_cmp++;
        if (state_dbg !== 3'd0 || bus.err_cnt !== 8'(exp_err)) begin
            n_bad++;
            $display("FAIL timeout_idle: got st=%0d cnt=%0d want st=0 cnt=%0d", state_dbg, bus.err_cnt, exp_err);
        end
        send_pkt(8'h00, 8'h00, 8'h05);
        n_cmp++;
        if ({bus.cmd_valid, bus.cmd_motor, bus.cmd_steps} !== {1'b1, 2'd0, 16'd5}) begin
            n_bad++;
            $display("FAIL timeout_recover: got v=%0b m=%0d s=%0d want v=1 m=0 s=5",
                     bus.cmd_valid, bus.cmd_motor, bus.cmd_steps);
        end
        @(posedge clk); #1;
        // Strobe arriving exactly in the last timer cycle must rescue the packet.
        send_byte(8'hA5);
        repeat (TO - 1) @(posedge clk);
        #1;
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h07);
`ifdef CMD_CHECKSUM_EN
        send_byte(8'h07);
`endif
        n_cmp++;
        if ({bus.cmd_valid, bus.cmd_steps} !== {1'b1, 16'd7} || bus.err_cnt !== 8'(exp_err)) begin
            n_bad++;
            $display("FAIL timeout_edge_strobe: got v=%0b s=%0d cnt=%0d want v=1 s=7 cnt=%0d",
                     bus.cmd_valid, bus.cmd_steps, bus.err_cnt, exp_err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        bus.cmd_ready = 1'b0;
        send_pkt(8'h41, 8'h12, 8'h34);
        send_pkt(8'hC3, 8'h00, 8'h07);
        exp_err++;
        n_cmp++;
        if (bus.pkt_err !== 1'b1 || bus.err_cnt !== 8'(exp_err)) begin
            n_bad++;
            $display("FAIL overrun_err: got e=%0b cnt=%0d want e=1 cnt=%0d", bus.pkt_err, bus.err_cnt, exp_err);
        end
        n_cmp++;
        if ({bus.cmd_valid, bus.cmd_dir, bus.cmd_half, bus.cmd_motor, bus.cmd_steps} !== {1'b1, 1'b0, 1'b1, 2'd1, 16'h1234}) begin
            n_bad++;
            $display("FAIL overrun_hold: got v=%0b d=%0b h=%0b m=%0d s=%0h want v=1 d=0 h=1 m=1 s=1234",
                     bus.cmd_valid, bus.cmd_dir, bus.cmd_half, bus.cmd_motor, bus.cmd_steps);
        end
        bus.cmd_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.cmd_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL overrun_single_xfer: got v=%0b want 0", bus.cmd_valid);
        end
        // Commit coinciding with the handshake replaces the held command without error.
        bus.cmd_ready = 1'b0;
        send_pkt(8'h01, 8'h00, 8'h01);
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
`ifdef CMD_CHECKSUM_EN
        send_byte(8'h03);
        bus.cmd_ready = 1'b1;
        send_byte(8'h01);
`else
        bus.cmd_ready = 1'b1;
        send_byte(8'h03);
`endif
        n_cmp++;
        if ({bus.cmd_valid, bus.cmd_motor, bus.cmd_steps, bus.pkt_err} !== {1'b1, 2'd2, 16'd3, 1'b0}
            || bus.err_cnt !== 8'(exp_err)) begin
            n_bad++;
            $display("FAIL same_cycle_handoff: got v=%0b m=%0d s=%0d e=%0b cnt=%0d want v=1 m=2 s=3 e=0 cnt=%0d",
                     bus.cmd_valid, bus.cmd_motor, bus.cmd_steps, bus.pkt_err, bus.err_cnt, exp_err);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (bus.cmd_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL handoff_drain: got v=%0b want 0", bus.cmd_valid);
        end
    endtask

    task automatic test_errors();
        send_byte(8'h00);
        send_byte(8'hFF);
        @(posedge clk); #1;
        n_cmp++;
        if (bus.err_cnt !== 8'(exp_err) || state_dbg !== 3'd0) begin
            n_bad++;
            $display("FAIL garbage_ignored: got cnt=%0d st=%0d want cnt=%0d st=0", bus.err_cnt, state_dbg, exp_err);
        end
        send_byte(8'hA5);
        send_byte(8'h3C);
        exp_err++;
        n_cmp++;
        if (bus.pkt_err !== 1'b1 || bus.err_cnt !== 8'(exp_err) || state_dbg !== 3'd0) begin
            n_bad++;
            $display("FAIL rsvd_err: got e=%0b cnt=%0d st=%0d want e=1 cnt=%0d st=0",
                     bus.pkt_err, bus.err_cnt, state_dbg, exp_err);
        end
        for (int i = 0; i < 300; i++) begin
            send_byte(8'hA5);
            send_byte(8'h3C);
            if (exp_err < 255) exp_err++;
        end
        n_cmp++;
        if (bus.err_cnt !== 8'd255 || bus.pkt_err !== 1'b1) begin
            n_bad++;
            $display("FAIL err_saturate: got cnt=%0d e=%0b want cnt=255 e=1", bus.err_cnt, bus.pkt_err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        bus.cmd_ready = 1'b0;
        send_pkt(8'h01, 8'h00, 8'h09);
        send_byte(8'hA5); send_byte(8'h81); send_byte(8'h01);
        n_cmp++;
        if (state_dbg !== 3'd3 || bus.cmd_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_pkt_state: got st=%0d v=%0b want st=3 v=1", state_dbg, bus.cmd_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.cmd_valid, bus.cmd_dir, bus.cmd_half, bus.cmd_motor, bus.cmd_steps, bus.pkt_err} !== 22'd0
            || bus.err_cnt !== 8'd0 || state_dbg !== 3'd0) begin
            n_bad++;
            $display("FAIL async_reset: got v=%0b s=%0d cnt=%0d st=%0d want all 0",
                     bus.cmd_valid, bus.cmd_steps, bus.err_cnt, state_dbg);
        end
        exp_err = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.cmd_ready = 1'b1;
        send_pkt(8'h81, 8'h01, 8'hF4);
        n_cmp++;
        if ({bus.cmd_valid, bus.cmd_dir, bus.cmd_motor, bus.cmd_steps} !== {1'b1, 1'b1, 2'd1, 16'd500}
            || bus.err_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL post_reset_pkt: got v=%0b d=%0b m=%0d s=%0d cnt=%0d want v=1 d=1 m=1 s=500 cnt=0",
                     bus.cmd_valid, bus.cmd_dir, bus.cmd_motor, bus.cmd_steps, bus.err_cnt);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
`ifdef CMD_CHECKSUM_EN
        test_checksum();
`endif
        test_timeout();
        test_back_to_back();
        test_errors();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
